blinker_top_entity_0: RTL and testbench
=======================================

BLINKER_TOP_ENTITY_0 -- requirements
Module: blinker_top_entity_0

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with clock port system1000 and reset port system1000_rstn; polarity and synchronicity are fixed regardless of the port name.
REQ-002 Parameter CNT_MAX, default 25_000_000: counter terminal value; one blink half-period is CNT_MAX+1 clock cycles.
REQ-003 Parameter CNT_W, default 32: counter width; CNT_W SHALL be at least clog2(CNT_MAX+1).
REQ-004 Parameter SYNC_STAGES, default 2: synchronizer depth on x_i1, minimum 2.
REQ-005 system1000  input  1  clock, nominal 1000 ps period, all logic on the rising edge.
REQ-006 system1000_rstn  input  1  synchronous active-high reset.
REQ-007 x_i1  input  1  asynchronous mode key, active-high, one press = one low-to-high transition.
REQ-008 topLet_o  output  1  LED drive, registered output.

Function
REQ-009 x_i1 SHALL pass through a SYNC_STAGES flip-flop synchronizer before use; all synchronizer stages SHALL be 0 while reset is asserted.
REQ-010 A rising-edge detector on the synchronized key SHALL produce a one-cycle press pulse; a key held high SHALL produce exactly one pulse.
REQ-011 Mode register: BLINK=0, HOLD=1; each press pulse SHALL toggle the mode.
REQ-012 Counter cntr SHALL increment by 1 every cycle while not in reset, and SHALL wrap from CNT_MAX to 0; the cycle at cntr==CNT_MAX is the tick.
REQ-013 On a tick in BLINK mode, topLet_o SHALL invert on the next clock edge.
REQ-014 On a tick in HOLD mode, topLet_o SHALL keep its value; the counter SHALL keep running.
REQ-015 Tick and press in the same cycle: the tick SHALL use the mode value before the toggle, and the new mode SHALL apply from the next tick.
REQ-016 A mode change SHALL NOT reset or disturb the counter phase.
REQ-017 Total latency from an x_i1 edge to the mode change SHALL be SYNC_STAGES+1 cycles.
REQ-018 topLet_o SHALL be driven only by a flip-flop, with no combinational path from any input.
REQ-019 The counter SHALL be unsigned, CNT_W bits; the comparison against CNT_MAX SHALL be exact equality.

Reset
REQ-020 While system1000_rstn==1 at a rising edge, the block SHALL set cntr=0, mode=BLINK, topLet_o=0, all synchronizer and edge-detector flops=0.
REQ-021 Reset SHALL take priority over tick and press in the same cycle.
REQ-022 After deassertion, the first tick SHALL occur CNT_MAX+1 cycles later, and topLet_o SHALL first go to 1 on the following edge.
REQ-023 Reset asserted mid-operation SHALL abandon the count immediately, with no output glitch beyond the registered update.
REQ-024 Before the first reset, output state is undefined; an X on x_i1 SHALL NOT propagate to topLet_o while reset is asserted.

Verification
REQ-025 Reset then run with CNT_MAX=3 and x_i1=0 -> topLet_o=0 for 4 cycles, then toggles every 4 cycles: 0,0,0,0,1,1,1,1,0....
REQ-026 CNT_MAX=3, one x_i1 pulse 0->1 held 10 cycles -> exactly one mode toggle to HOLD, and topLet_o frozen at its current value through later ticks.
REQ-027 Second press -> returns to BLINK, and toggling resumes at the next tick with unchanged counter phase.
REQ-028 Press timed so the detector pulse coincides with cntr==CNT_MAX -> that tick still toggles (old mode BLINK), and later ticks hold.
REQ-029 Assert reset for 1 cycle with topLet_o=1 mid-count -> topLet_o=0 and cntr=0 next cycle, and the first toggle occurs CNT_MAX+1 cycles after release.
REQ-030 Drive x_i1=X during reset -> topLet_o=0 and no X on topLet_o.

Source files
------------

// File: rtl/blinker_top_entity_0.sv
// LED blinker: a free-running counter sets the blink half-period, and a
// synchronized, edge-detected key press toggles between blinking and holding.
module blinker_top_entity_0 #(
  parameter int CNT_MAX     = 25_000_000,
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic system1000,
  input  logic system1000_rstn,
  input  logic x_i1,
  output logic topLet_o
);

  typedef enum logic {
    BLINK = 1'b0,
    HOLD  = 1'b1
  } mode_t;

  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   key_prev;
  mode_t                  mode;
  logic [CNT_W-1:0]       cntr;

  logic key;
  logic press;
  logic tick;

  assign key   = sync[SYNC_STAGES-1];
  assign press = key & ~key_prev;
  assign tick  = (cntr == CNT_TOP);

  // The reset port is active-high despite its name.
  // A tick and a press in the same cycle both read the old mode, so that
  // tick still follows the pre-toggle mode.
  always_ff @(posedge system1000) begin
    if (system1000_rstn) begin
      sync     <= '0;
      key_prev <= 1'b0;
      mode     <= BLINK;
      cntr     <= '0;
      topLet_o <= 1'b0;
    end else begin
      sync     <= {sync[SYNC_STAGES-2:0], x_i1};
      key_prev <= key;
      cntr     <= tick ? '0 : cntr + CNT_ONE;
      if (tick && (mode == BLINK)) begin
        topLet_o <= ~topLet_o;
      end
      if (press) begin
        mode <= (mode == BLINK) ? HOLD : BLINK;
      end
    end
  end

endmodule

// File: tb/tb_blinker_top_entity_0.sv
// Testbench for blinker_top_entity_0: directed reset/press scenarios, then
// randomized key and reset activity, all checked against a cycle-count model.
`timescale 1ps/1ps
module tb_blinker_top_entity_0;

  localparam int CM = 3;
  localparam int S  = 2;

  logic clk;
  logic rst;
  logic x;
  logic led;

  int compared;
  int mismatched;

  int unsigned cyc;
  bit          m_mode;
  logic        m_led;
  logic        hist[$];
  bit          have_reset;

  blinker_top_entity_0 #(
    .CNT_MAX(CM),
    .CNT_W(8),
    .SYNC_STAGES(S)
  ) dut (
    .system1000(clk),
    .system1000_rstn(rst),
    .x_i1(x),
    .topLet_o(led)
  );

  initial clk = 1'b0;
  always #500 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, observed, expected);
    end
  endtask

  // The model counts cycles since reset; a tick is every (CM+1)th cycle, and
  // the mode flips S+1 edges after a sampled 0->1 transition of the key.
  task automatic runCycle();
    bit tick_m;
    bit press_m;
    @(posedge clk);
    if (rst) begin
      cyc    = 0;
      m_mode = 1'b0;
      m_led  = 1'b0;
      hist   = {};
      for (int i = 0; i < S + 1; i++) hist.push_back(1'b0);
      have_reset = 1'b1;
    end else if (have_reset) begin
      tick_m  = ((cyc % (CM + 1)) == CM);
      press_m = (hist[S-1] === 1'b1) && (hist[S] === 1'b0);
      if (tick_m && !m_mode) m_led = ~m_led;
      if (press_m) m_mode = ~m_mode;
      cyc++;
      hist.push_front(x);
      void'(hist.pop_back());
    end
    @(negedge clk);
    if (have_reset) begin
      checkOutput("led", {31'd0, led}, {31'd0, m_led});
      checkOutput("cntr", {24'd0, dut.cntr}, cyc % (CM + 1));
    end
  endtask

  task automatic applyStimulus(input logic rst_v, input logic x_v, input int n);
    rst = rst_v;
    x   = x_v;
    for (int i = 0; i < n; i++) runCycle();
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    have_reset = 1'b0;
    cyc        = 0;
    rst        = 1'b1;
    x          = 1'bx;
    @(negedge clk);

    // Unknown key while in reset must not reach the LED.
    applyStimulus(1'b1, 1'bx, 3);
    applyStimulus(1'b0, 1'b0, 14);
    // Long press gives one toggle into HOLD, then a second press back to BLINK.
    applyStimulus(1'b0, 1'b1, 10);
    applyStimulus(1'b0, 1'b0, 10);
    applyStimulus(1'b0, 1'b1, 4);
    applyStimulus(1'b0, 1'b0, 12);
    // One-cycle reset mid-count.
    applyStimulus(1'b1, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 10);
    // Presses at every counter phase so a press lands on a tick.
    for (int ph = 0; ph < 2 * (CM + 1); ph++) begin
      applyStimulus(1'b0, 1'b0, ph + 1);
      applyStimulus(1'b0, 1'b1, 3);
      applyStimulus(1'b0, 1'b0, 6);
    end

    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 19) == 0)
        applyStimulus(1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(1, 2)));
      else
        applyStimulus(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(1, 12)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
